// File: rtl/cla_pkg.sv
// cla_pkg: shared width, operand type and carry-out helper for the 108-bit adder path
package cla_pkg;
  localparam int CLA_W = 108;
  typedef logic [CLA_W-1:0] cla_word_t;
  function automatic logic cla_cout(input logic pm, input logic gm, input logic cin);
    return gm | (pm & cin);
  endfunction
endpackage

// File: rtl/cla_108bits.sv
// cla_108bits: 108-bit two-level carry-lookahead adder with group propagate/generate outputs
module cla_108bits
  import cla_pkg::*;
(
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      cin,
  output cla_word_t sum,
  output logic      pm,
  output logic      gm
);
  localparam int NG = CLA_W/4;
  cla_word_t p, g, c;
  logic [NG-1:0] bg, bp;
  logic [NG:0] bc;
  logic gacc, pacc;
  assign p = a ^ b;
  assign g = a & b;
  // 4-bit lookahead blocks; block carries chain, gm/pm fold the blocks with zero carry-in
  always_comb begin
    c = '0;
    bg = '0;
    bp = '0;
    bc = '0;
    bc[0] = cin;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int k = 0; k < NG; k++) begin
      bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k] = &p[4*k +: 4];
      c[4*k] = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
      gacc = bg[k] | (bp[k] & gacc);
      pacc = pacc & bp[k];
    end
  end
  assign sum = p ^ c;
  assign gm = gacc;
  assign pm = pacc;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus encoded index
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  // scan from the farthest position back to ptr so the nearest requester wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N-1; k >= 0; k--)
      if (req[(int'(ptr)+k)%N]) begin
        grant = '0;
        grant[(int'(ptr)+k)%N] = 1'b1;
        idx = IW'((int'(ptr)+k)%N);
      end
  end
endmodule

// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter: round-robin sharing of one 108-bit CLA adder with a registered valid/ready response
module cla_add_arbiter
  import cla_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CLA_W-1:0] req_a,
  input  logic [NREQ*CLA_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CLA_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic [7:0]            busy_cnt
);
  logic [IDW-1:0] ptr, idx;
  logic [NREQ-1:0] grant;
  logic can_accept, any_grant, accept, cin_sel, pm, gm;
  cla_word_t a_sel, b_sel, sum;
  assign can_accept = !rsp_valid || rsp_ready;
  assign any_grant = |grant;
  // rst_n gates ready so nothing is handed off while reset is held
  assign req_ready = (can_accept && rst_n) ? grant : '0;
  assign accept = |req_ready;
  assign a_sel = any_grant ? req_a[int'(idx)*CLA_W +: CLA_W] : '0;
  assign b_sel = any_grant ? req_b[int'(idx)*CLA_W +: CLA_W] : '0;
  assign cin_sel = any_grant && req_cin[idx];
  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (.req(req_valid), .ptr(ptr), .grant(grant), .idx(idx));
  cla_108bits u_add (.a(a_sel), .b(b_sel), .cin(cin_sel), .sum(sum), .pm(pm), .gm(gm));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_id <= '0;
      busy_cnt <= '0;
      ptr <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_sum <= sum;
        rsp_cout <= cla_cout(pm, gm, cin_sel);
        rsp_id <= idx;
        ptr <= (int'(idx) == NREQ-1) ? '0 : idx + 1'b1;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      if (|req_valid && !can_accept && busy_cnt != 8'hff) busy_cnt <= busy_cnt + 8'd1;
    end
endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb_cla_add_arbiter: scoreboard bench for the shared CLA adder arbiter
module tb_cla_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int W = 108;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, req_cin;
  logic [NREQ*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_cout;
  logic [W-1:0] rsp_sum;
  logic [IDW-1:0] rsp_id;
  logic [7:0] busy_cnt;
  logic [W-1:0] ra [NREQ];
  logic [W-1:0] rb [NREQ];
  int total = 0, bad = 0;
  logic [IDW+W:0] q [$];
  logic rv_m;
  int busy_m, ptr_m;
  logic [NREQ-1:0] acc_m;
  logic [W-1:0] s0;
  logic [IDW-1:0] i0;
  int b0;
  int rr_exp [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int two_exp [3] = '{3, 0, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*W +: W] = ra[g];
    assign req_b[g*W +: W] = rb[g];
  end

  cla_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .busy_cnt(busy_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_model(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] one;
    one = 1;
    for (int k = 0; k < NREQ; k++)
      if (v[(p+k)%NREQ]) return one << ((p+k)%NREQ);
    return '0;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] r;
    int s;
    r = {$urandom, $urandom, $urandom, $urandom};
    s = $urandom_range(0, 7);
    return s == 0 ? '1 : s == 1 ? '0 : r[W-1:0];
  endfunction

  // inputs are already driven at the falling edge; check, update model, advance one cycle
  task automatic step();
    logic [NREQ-1:0] g;
    logic [IDW+W:0] e;
    logic ca;
    #1;
    ca = !rv_m || rsp_ready;
    g = rr_model(req_valid, ptr_m);
    acc_m = ca ? g : '0;
    chk("req_ready", req_ready, acc_m);
    chk("rsp_valid", rsp_valid, rv_m);
    chk("busy_cnt", busy_cnt, busy_m);
    if (rv_m) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q[0];
        chk("rsp_id", rsp_id, e[IDW+W:W+1]);
        chk("rsp_cout_sum", {rsp_cout, rsp_sum}, e[W:0]);
        if (rsp_ready) void'(q.pop_front());
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (acc_m[i]) begin
        q.push_back({IDW'(i), {1'b0, ra[i]} + {1'b0, rb[i]} + (W+1)'(req_cin[i])});
        ptr_m = (i + 1) % NREQ;
      end
    if (|req_valid && !ca && busy_m < 255) busy_m++;
    rv_m = |acc_m ? 1'b1 : rsp_ready ? 1'b0 : rv_m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy_cnt, 0);
    chk("rst_ready", req_ready, 0);
  endtask

  initial begin
    req_valid = '1;
    req_cin = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = rnd();
      rb[i] = rnd();
    end
    rv_m = 1'b0;
    busy_m = 0;
    ptr_m = 0;
    acc_m = '0;
    @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_seq_id", rsp_id, rr_exp[k]);
    end
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_pair_id", rsp_id, two_exp[k]);
    end
    req_valid = 4'b0010;
    ra[1] = '1;
    rb[1] = 1;
    req_cin[1] = 1'b0;
    step();
    chk("carry_sum", rsp_sum, 0);
    chk("carry_cout", rsp_cout, 1);
    chk("carry_id", rsp_id, 1);
    ra[1] = '0;
    rb[1] = '0;
    req_cin[1] = 1'b1;
    step();
    chk("cin_sum", rsp_sum, 1);
    chk("cin_cout", rsp_cout, 0);
    req_valid = 4'b0001;
    step();
    s0 = rsp_sum;
    i0 = rsp_id;
    b0 = busy_cnt;
    ra[0] = rnd();
    rb[0] = rnd();
    req_cin[0] = 1'b1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("bp_sum_stable", rsp_sum, s0);
    chk("bp_id_stable", rsp_id, i0);
    chk("bp_busy_plus5", busy_cnt, b0 + 5);
    rsp_ready = 1'b1;
    step();
    chk("bp_release_sum", {rsp_cout, rsp_sum}, {1'b0, ra[0]} + {1'b0, rb[0]} + 109'd1);
    ra[0] = rnd();
    rb[0] = rnd();
    rsp_ready = 1'b0;
    for (int k = 0; k < 300; k++) step();
    chk("busy_sat", busy_cnt, 255);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    req_valid = 4'b0100;
    ra[2] = rnd() | 1;
    rb[2] = rnd();
    rsp_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    q.delete();
    rv_m = 1'b0;
    busy_m = 0;
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ra[2] = rnd();
    rsp_ready = 1'b1;
    step();
    chk("post_rst_id", rsp_id, 2);
    req_valid = '0;
    step();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (acc_m[i] || !req_valid[i]) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          ra[i] = rnd();
          rb[i] = rnd();
          req_cin[i] = 1'($urandom_range(0, 1));
        end
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
- Shares one 108-bit carry-lookahead adder (existing `cla_108bits` datapath) between NREQ independent requesters.
- Round-robin arbitration chooses one request per cycle; its operands go through the adder in the same cycle.
- The sum, carry-out and requester id are captured in a single output register and presented on a valid/ready response port.
- Sits between the operand-producing units of the multi-precision arithmetic path and the adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_a  input  NREQ*108  operand A, requester i on bits [i*108 +: 108].
- req_b  input  NREQ*108  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_sum  output  108  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_id  output  IDW  index of the requester that produced the result.
- busy_cnt  output  8  saturating count of cycles in which requests were stalled by backpressure.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy_cnt=0.
  - Round-robin pointer ptr=0.
  - Reset takes effect immediately, including mid-transfer. A held result is discarded and no req_ready is asserted while rst_n is low.
- Output register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready. Accepting a new result in the same cycle the held result is drained is legal, giving full throughput.
- Arbitration is combinational:
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, … (modulo NREQ).
  - req_ready[i] = grant[i] & can_accept.
  - req_ready never asserts for a requester with req_valid=0.
  - Requesters must not make req_valid depend on req_ready.
  - Once req_valid is asserted, a requester holds req_valid and its operands stable until it is accepted.
- Accept (any req_ready[i]=1 at a clock edge):
  - Adder inputs are taken from requester i.
  - rsp_sum <= a+b+cin (low 108 bits).
  - rsp_cout <= gm | (pm & cin), using the adder's group propagate/generate outputs.
  - rsp_id <= i; rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- No accept but rsp_ready=1: rsp_valid <= 0; data outputs keep their last values.
- No accept and rsp_ready=0: all response outputs hold.
- ptr changes only on accept.
- Latency: accept at edge t, so rsp_valid is high in cycle t+1. Sustained throughput is 1 result per cycle.
- Zero-request cycle: grant all zero, ptr unchanged, adder inputs driven 0.
- busy_cnt increments by 1, saturating at 255, in each cycle with |req_valid=1 and can_accept=0.

Decomposition:
- Shared package `cla_pkg`:
  - constant CLA_W=108;
  - typedef for 108-bit operand;
  - function computing carry-out from pm, gm and cin.
- Sub-module `rr_arbiter` (parameter N): inputs req[N] and ptr; output one-hot grant[N] and encoded index. Pure combinational, reusable by other shared-unit controllers.
- The adder is an instance of `cla_108bits`.
- The output register, pointer and counter stay in the top.

Test Plan:
- Reset:
  - Stimulus: assert rst_n low mid-stream while rsp_valid=1.
  - Required: rsp_valid, rsp_sum, rsp_cout and busy_cnt read 0 immediately, without waiting for an edge; req_ready=0.
  - After release with req 2 valid: rsp_id=2 appears one cycle after accept.
- Carry boundary:
  - Stimulus: requester 1 sends a=108'hFFF…F, b=1, cin=0.
  - Required: next cycle rsp_sum=0, rsp_cout=1, rsp_id=1.
  - Stimulus: a=0, b=0, cin=1. Required: rsp_sum=1, rsp_cout=0.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0,1 with rsp_valid high every cycle.
  - Stimulus: only req 3 and req 0 valid, ptr=1. Required: grant order 3,0,3.
- Backpressure:
  - Stimulus: rsp_valid=1, rsp_ready=0 for 5 cycles with req 0 valid.
  - Required: req_ready=0 throughout; rsp_sum/rsp_id stable; busy_cnt +5.
  - Stimulus: rsp_ready rises. Required: req 0 is accepted in that same cycle and the new result is visible the next cycle.
- busy_cnt saturation:
  - Stimulus: hold a request with rsp_ready=0 for 300 cycles.
  - Required: busy_cnt stops at 255.
- Random:
  - Stimulus: 10k random operands, valids and rsp_ready.
  - Required: every accepted request yields exactly one response with matching id and {cout,sum} = a+b+cin (109-bit reference model); no loss, no duplicates.
